// File: rtl/calc_sequencer_pkg.sv
// calc_pkg: shared types and constants for the calculator sequencer.
//   op_t        - ALU operator encoding (add, sub, mul, div)
//   seq_state_t - sequencer FSM states; EMIT_NL exists only when
//                 CALC_SEQ_NEWLINE_EN is defined
//   ASCII_*     - characters written to the TX FIFO
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LAUNCH      = 3'd1,
        ST_WAIT_ALU    = 3'd2,
        ST_CONVERT     = 3'd3,
        ST_EMIT_SIGN   = 3'd4,
        ST_EMIT_DIGITS = 3'd5,
`ifdef CALC_SEQ_NEWLINE_EN
        ST_EMIT_ERR    = 3'd6,
        ST_EMIT_NL     = 3'd7
`else
        ST_EMIT_ERR    = 3'd6
`endif
    } seq_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_R     = 8'h52;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: operand/ALU/TX-FIFO signal bundle of the sequencer.
//   master modport - the sequencer side (drives ALU launch, TX writes, status)
//   slave  modport - the environment side (input processor, ALU, TX FIFO)
interface calc_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WIDTH  = 16,
    parameter int RES_WIDTH  = 32
);
    logic [NUM_WIDTH-1:0]  num1_in;
    logic [NUM_WIDTH-1:0]  num2_in;
    logic [1:0]            operator_in;
    logic                  start_calc_in;
    logic                  alu_start_o;
    logic [NUM_WIDTH-1:0]  alu_a_o;
    logic [NUM_WIDTH-1:0]  alu_b_o;
    logic [1:0]            alu_op_o;
    logic                  alu_done_in;
    logic [RES_WIDTH-1:0]  alu_result_in;
    logic                  alu_err_in;
    logic                  tx_full_in;
    logic                  tx_wen_o;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        input  num1_in, num2_in, operator_in, start_calc_in,
        input  alu_done_in, alu_result_in, alu_err_in, tx_full_in,
        output alu_start_o, alu_a_o, alu_b_o, alu_op_o,
        output tx_wen_o, tx_data_o, busy_o, err_o
    );

    modport slave (
        output num1_in, num2_in, operator_in, start_calc_in,
        output alu_done_in, alu_result_in, alu_err_in, tx_full_in,
        input  alu_start_o, alu_a_o, alu_b_o, alu_op_o,
        input  tx_wen_o, tx_data_o, busy_o, err_o
    );
endinterface

// File: rtl/calc_sequencer_bin2bcd.sv
// bin2bcd: sequential double-dabble binary to BCD converter.
//   clk, rst_n  - clock, synchronous active-low reset
//   start_i     - one-cycle pulse, loads bin_i
//   bin_i       - unsigned binary value
//   done_o      - one-cycle pulse, BIN_WIDTH+1 cycles after start_i
//   bcd_o       - DIGITS packed BCD nibbles, digit 0 in the low nibble
module bin2bcd #(
    parameter int BIN_WIDTH = 32,
    parameter int DIGITS    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_WIDTH-1:0]  bin_i,
    output logic                  done_o,
    output logic [DIGITS*4-1:0]   bcd_o
);
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0] r_bin;
    logic [DIGITS*4-1:0]  r_bcd;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_active;
    logic                 r_done;
    logic [DIGITS*4-1:0]  w_adj;
    logic                 w_unused_msb;

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The top bit can never be set when DIGITS covers the input range.
    assign w_unused_msb = w_adj[DIGITS*4-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start_i) begin
                r_bin    <= bin_i;
                r_bcd    <= '0;
                r_cnt    <= CNT_W'(BIN_WIDTH);
                r_active <= 1'b1;
            end else if (r_active) begin
                r_bcd <= {w_adj[DIGITS*4-2:0], r_bin[BIN_WIDTH-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done_o = r_done;
    assign bcd_o  = r_bcd;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: latches an operand pair, runs one ALU operation through a
// start/done handshake, converts the result to zero-suppressed decimal ASCII
// and streams it into the TX FIFO under full-flag backpressure.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - calc_sequencer_if.master: operands/request, ALU handshake,
//                TX FIFO write port, busy/err status
// Optional feature: define CALC_SEQ_NEWLINE_EN to terminate every line
// (result or "ERR") with CR, LF.
//
// state          | meaning
// ST_IDLE        | waiting for start_calc_in
// ST_LAUNCH      | alu_start_o pulse
// ST_WAIT_ALU    | waiting for alu_done_in or timeout
// ST_CONVERT     | binary to BCD conversion running
// ST_EMIT_SIGN   | writing '-'
// ST_EMIT_DIGITS | writing digits, most significant nonzero first
// ST_EMIT_ERR    | writing "ERR"
// ST_EMIT_NL     | writing CR, LF (newline build only)
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WIDTH  = 16,
    parameter int RES_WIDTH  = 32,
    parameter int DIGITS     = 10,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    calc_sequencer_if.master bus
);
    localparam int IDX_W = (DIGITS > 4) ? $clog2(DIGITS) : 2;
    localparam int TMO_W = $clog2(TIMEOUT);

    seq_state_t          r_state;
    seq_state_t          w_next;
    seq_state_t          w_line_end;
    logic [NUM_WIDTH-1:0] r_a;
    logic [NUM_WIDTH-1:0] r_b;
    op_t                 r_op;
    logic                r_err;
    logic                r_neg;
    logic [RES_WIDTH-1:0] r_mag;
    logic                r_bcd_start;
    logic [DIGITS*4-1:0] r_digits;
    logic [IDX_W-1:0]    r_idx;
    logic [TMO_W-1:0]    r_tmo;

    logic                w_bcd_done;
    logic [DIGITS*4-1:0] w_bcd;
    logic [IDX_W-1:0]    w_top_idx;
    logic [3:0]          w_digit;
    logic                w_neg;
    logic                w_tmo_hit;
    logic                w_emit;
    logic                w_wr;
    logic [7:0]          w_tx_data;

    bin2bcd #(
        .BIN_WIDTH (RES_WIDTH),
        .DIGITS    (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (r_bcd_start),
        .bin_i   (r_mag),
        .done_o  (w_bcd_done),
        .bcd_o   (w_bcd)
    );

`ifdef CALC_SEQ_NEWLINE_EN
    assign w_line_end = ST_EMIT_NL;
`else
    assign w_line_end = ST_IDLE;
`endif

    assign w_neg     = (r_op == OP_SUB) && bus.alu_result_in[RES_WIDTH-1];
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_digit   = r_digits[4*r_idx +: 4];

    // Position of the most significant nonzero digit; 0 for a zero result,
    // which then emits the single digit '0'.
    always_comb begin
        w_top_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd[4*i +: 4] != 4'd0) begin
                w_top_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:        if (bus.start_calc_in) w_next = ST_LAUNCH;
            ST_LAUNCH:      w_next = ST_WAIT_ALU;
            ST_WAIT_ALU: begin
                // done has priority over a coincident timeout
                if (bus.alu_done_in) begin
                    w_next = bus.alu_err_in ? ST_EMIT_ERR : ST_CONVERT;
                end else if (w_tmo_hit) begin
                    w_next = ST_EMIT_ERR;
                end
            end
            ST_CONVERT:     if (w_bcd_done) w_next = r_neg ? ST_EMIT_SIGN : ST_EMIT_DIGITS;
            ST_EMIT_SIGN:   if (w_wr) w_next = ST_EMIT_DIGITS;
            ST_EMIT_DIGITS: if (w_wr && (r_idx == '0)) w_next = w_line_end;
            ST_EMIT_ERR:    if (w_wr && (r_idx == IDX_W'(2))) w_next = w_line_end;
`ifdef CALC_SEQ_NEWLINE_EN
            ST_EMIT_NL:     if (w_wr && (r_idx == IDX_W'(1))) w_next = ST_IDLE;
`endif
            default:        w_next = ST_IDLE;
        endcase
    end

    // tx_data_o depends only on state and index, so it holds while full.
    always_comb begin
        w_emit    = 1'b0;
        w_tx_data = 8'h00;
        case (r_state)
            ST_EMIT_SIGN: begin
                w_emit    = 1'b1;
                w_tx_data = ASCII_MINUS;
            end
            ST_EMIT_DIGITS: begin
                w_emit    = 1'b1;
                w_tx_data = ASCII_ZERO + {4'h0, w_digit};
            end
            ST_EMIT_ERR: begin
                w_emit    = 1'b1;
                w_tx_data = (r_idx == '0) ? ASCII_E : ASCII_R;
            end
`ifdef CALC_SEQ_NEWLINE_EN
            ST_EMIT_NL: begin
                w_emit    = 1'b1;
                w_tx_data = (r_idx == '0) ? ASCII_CR : ASCII_LF;
            end
`endif
            default: ;
        endcase
        w_wr = w_emit && !bus.tx_full_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= OP_ADD;
            r_err       <= 1'b0;
            r_neg       <= 1'b0;
            r_mag       <= '0;
            r_bcd_start <= 1'b0;
            r_digits    <= '0;
            r_idx       <= '0;
            r_tmo       <= '0;
        end else begin
            r_bcd_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_calc_in) begin
                        r_a   <= bus.num1_in;
                        r_b   <= bus.num2_in;
                        r_op  <= op_t'(bus.operator_in);
                        r_err <= 1'b0;
                    end
                end
                ST_LAUNCH: r_tmo <= '0;
                ST_WAIT_ALU: begin
                    if (bus.alu_done_in) begin
                        if (bus.alu_err_in) begin
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_neg       <= w_neg;
                            r_mag       <= w_neg ? (~bus.alu_result_in + RES_WIDTH'(1))
                                                 : bus.alu_result_in;
                            r_bcd_start <= 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                        r_idx <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (w_bcd_done) begin
                        r_digits <= w_bcd;
                        r_idx    <= w_top_idx;
                    end
                end
                // the index ends each phase at 0, ready for the next one
                ST_EMIT_DIGITS: if (w_wr && (r_idx != '0)) r_idx <= r_idx - 1'b1;
                ST_EMIT_ERR:    if (w_wr) r_idx <= (r_idx == IDX_W'(2)) ? '0 : r_idx + 1'b1;
`ifdef CALC_SEQ_NEWLINE_EN
                ST_EMIT_NL:     if (w_wr) r_idx <= (r_idx == IDX_W'(1)) ? '0 : r_idx + 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign bus.alu_start_o = (r_state == ST_LAUNCH);
    assign bus.alu_a_o     = r_a;
    assign bus.alu_b_o     = r_b;
    assign bus.alu_op_o    = r_op;
    assign bus.tx_wen_o    = w_wr;
    assign bus.tx_data_o   = DATA_WIDTH'(w_tx_data);
    assign bus.busy_o      = (r_state != ST_IDLE);
    assign bus.err_o       = r_err;

endmodule
